axi_lite_bram_master: RTL and testbench

AXI4-Lite initiator that moves runs of 32-bit words between a streaming client and the AXI-Lite slave port of the dual-port BRAM. It turns one command (direction, start address, word count) into a series of single-beat AXI-Lite reads or writes, with one transaction outstanding at a time. It sits between the neural-net control logic and the BRAM's AXI port, opposite the native port B.

---
 rtl/axi_lite_bram_master.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_bram_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_bram_master.sv
// AXI4-Lite initiator: turns one (dir, addr, len) command into a run of
// single-beat reads or writes against the BRAM slave, one transaction in flight.
module axi_lite_bram_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [31:0]           rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] M_AXI_awaddr,
    output logic [2:0]            M_AXI_awprot,
    output logic                  M_AXI_awvalid,
    input  logic                  M_AXI_awready,
    output logic [31:0]           M_AXI_wdata,
    output logic [3:0]            M_AXI_wstrb,
    output logic                  M_AXI_wvalid,
    input  logic                  M_AXI_wready,
    input  logic [1:0]            M_AXI_bresp,
    input  logic                  M_AXI_bvalid,
    output logic                  M_AXI_bready,
    output logic [ADDR_WIDTH-1:0] M_AXI_araddr,
    output logic [2:0]            M_AXI_arprot,
    output logic                  M_AXI_arvalid,
    input  logic                  M_AXI_arready,
    input  logic [31:0]           M_AXI_rdata,
    input  logic [1:0]            M_AXI_rresp,
    input  logic                  M_AXI_rvalid,
    output logic                  M_AXI_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_FETCH, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP, RD_OUT, DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    // Holds cmd_ready low until the first edge after reset release.
    logic                  live_q;

    assign cmd_ready     = (state_q == IDLE) && live_q;
    assign wr_ready      = (state_q == WR_FETCH);
    assign M_AXI_awvalid = (state_q == WR_ISSUE) && !aw_done_q;
    assign M_AXI_wvalid  = (state_q == WR_ISSUE) && !w_done_q;
    assign M_AXI_bready  = (state_q == WR_RESP);
    assign M_AXI_arvalid = (state_q == RD_ISSUE);
    assign M_AXI_rready  = (state_q == RD_RESP);
    assign rd_valid      = (state_q == RD_OUT);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = (state_q == DONE) && err_q;
    assign M_AXI_awaddr  = addr_q;
    assign M_AXI_araddr  = addr_q;
    assign M_AXI_wdata   = wdata_q;
    assign M_AXI_wstrb   = 4'hF;
    assign M_AXI_awprot  = 3'b000;
    assign M_AXI_arprot  = 3'b000;
    assign rd_data       = rdata_q;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            live_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr & ~ADDR_WIDTH'(3);
                    rem_d   = cmd_len;
                    err_d   = 1'b0;
                    state_d = cmd_write ? WR_FETCH : RD_ISSUE;
                end
            end
            WR_FETCH: begin
                if (wr_valid) begin
                    wdata_d = wr_data;
                    state_d = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                // AW and W retire independently; leave once both have gone.
                aw_done_d = aw_done_q || (M_AXI_awvalid && M_AXI_awready);
                w_done_d  = w_done_q || (M_AXI_wvalid && M_AXI_wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_bvalid) begin
                    err_d = err_q || (M_AXI_bresp != 2'b00);
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = WR_FETCH;
                    end
                end
            end
            RD_ISSUE: begin
                if (M_AXI_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (M_AXI_rvalid) begin
                    rdata_d = M_AXI_rdata;
                    err_d   = err_q || (M_AXI_rresp != 2'b00);
                    state_d = RD_OUT;
                end
            end
            RD_OUT: begin
                if (rd_ready) begin
                    if (rem_q == '0) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(4);
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_bram_master.sv
// Randomised bench: AXI-Lite BRAM slave with random stalls/errors, a word-array
// reference model, and a scoreboard monitor checking every handshake.
module tb_axi_lite_bram_master;
    localparam int AW = 12;
    localparam int LW = 10;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 0, wr_ready, rd_valid, rd_ready = 0;
    logic [31:0]   wr_data = '0, rd_data;
    logic          busy, done, err;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
    logic          arvalid, arready = 0, rvalid = 0, rready;
    logic [31:0]   wdata, rdata = '0;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = '0, rresp = '0;

    axi_lite_bram_master #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
        .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
        .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
        .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
    );

    typedef struct packed { logic wr; logic err; } done_t;

    logic [31:0]   smem [1024];   // slave BRAM contents
    logic [31:0]   mmem [1024];   // reference model of the same BRAM
    logic [AW-1:0] exp_aw[$], exp_ar[$];
    logic [31:0]   exp_w[$], exp_rd[$], wr_feed[$], wdata_src[$];
    done_t         exp_done[$];
    bit            plan_b[$], plan_r[$], err_force[$];

    int n_chk = 0, n_pass = 0, cyc = 0;
    int max_dly = 0, wr_gap = 0, rd_mode = 0;
    bit lat3 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(act === exp, name, act, exp);
    endtask

    function automatic int pick();
        return int'($urandom_range(0, max_dly));
    endfunction

    // Slave, write-data source and rd_ready driver; everything changes 1ns after the edge.
    initial begin : drive
        bit aw_f, w_f, b_f, ar_f, r_f, wr_f, e;
        logic [AW-1:0] awa, ara, aw_l, ar_l;
        logic [31:0] wd, w_l;
        bit aw_got, w_got, ar_got;
        int aw_c, aw_d, w_c, w_d, b_c, b_d, ar_c, ar_d, r_c, r_d;
        aw_got = 0; w_got = 0; ar_got = 0; aw_l = '0; ar_l = '0; w_l = '0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
        forever begin
            @(negedge clk);
            aw_f = awvalid && awready; w_f = wvalid && wready; b_f = bvalid && bready;
            ar_f = arvalid && arready; r_f = rvalid && rready; wr_f = wr_valid && wr_ready;
            awa = awaddr; ara = araddr; wd = wdata;
            @(posedge clk); #1;
            if (!rst_n) begin
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
                aw_d = pick(); w_d = pick(); b_d = pick(); ar_d = pick(); r_d = pick();
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; wr_valid = 0;
            end else begin
                if (aw_f) begin awready = 0; aw_got = 1; aw_l = awa; aw_c = 0; aw_d = pick(); end
                else if (awvalid && !aw_got) begin awready = (aw_c >= aw_d); aw_c++; end
                if (w_f) begin wready = 0; w_got = 1; w_l = wd; w_c = 0; w_d = pick(); end
                else if (wvalid && !w_got) begin wready = (w_c >= w_d); w_c++; end
                if (b_f) bvalid = 0;
                if (aw_got && w_got && !bvalid) begin
                    if (b_c >= b_d) begin
                        smem[aw_l[AW-1:2]] = w_l;
                        e = (plan_b.size() != 0) ? plan_b.pop_front() : 1'b0;
                        bresp = e ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
                        bvalid = 1; aw_got = 0; w_got = 0; b_c = 0; b_d = pick();
                    end else b_c++;
                end
                if (ar_f) begin arready = 0; ar_got = 1; ar_l = ara; ar_c = 0; ar_d = pick(); end
                else if (arvalid && !ar_got) begin arready = (ar_c >= ar_d); ar_c++; end
                if (r_f) rvalid = 0;
                if (ar_got && !rvalid) begin
                    if (r_c >= r_d) begin
                        rdata = smem[ar_l[AW-1:2]];
                        e = (plan_r.size() != 0) ? plan_r.pop_front() : 1'b0;
                        rresp = e ? {1'b1, 1'($urandom_range(0, 1))} : 2'b00;
                        rvalid = 1; ar_got = 0; r_c = 0; r_d = pick();
                    end else r_c++;
                end
                if (wr_f) wr_valid = 0;
                if (!wr_valid && wr_feed.size() != 0 && $urandom_range(0, wr_gap) == 0) begin
                    wr_valid = 1; wr_data = wr_feed.pop_front();
                end
                case (rd_mode)
                    0:       rd_ready = 1;
                    1:       rd_ready = ~rd_ready;
                    default: rd_ready = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    // Scoreboard monitor: sampled mid-cycle, so valid&&ready here means a handshake at the next edge.
    initial begin : mon
        logic pv_aw, pv_w, pv_ar, pv_rd;
        logic [AW-1:0] p_awa, p_ara;
        logic [31:0] p_wd, p_rdd;
        bit busy_exp;
        int last_b, last_rd, last_wr;
        done_t dn;
        pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rd = 0; busy_exp = 0;
        p_awa = '0; p_ara = '0; p_wd = '0; p_rdd = '0;
        last_b = -100; last_rd = -100; last_wr = -100;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rd = 0; busy_exp = 0;
            end else begin
                if (pv_aw) chk_eq("aw_hold", {19'd0, awvalid, awaddr}, {19'd0, 1'b1, p_awa});
                if (pv_w)  chk_eq("w_hold_valid", 32'(wvalid), 32'd1);
                if (pv_w)  chk_eq("w_hold_data", wdata, p_wd);
                if (pv_ar) chk_eq("ar_hold", {19'd0, arvalid, araddr}, {19'd0, 1'b1, p_ara});
                if (pv_rd) chk_eq("rd_hold_valid", 32'(rd_valid), 32'd1);
                if (pv_rd) chk_eq("rd_hold_data", rd_data, p_rdd);
                chk_eq("busy", 32'(busy), 32'(busy_exp));
                chk_eq("cmd_ready", 32'(cmd_ready), 32'(!busy_exp));
                if (awvalid && awready) begin
                    chk(exp_aw.size() != 0, "aw_extra", 32'(awaddr), 32'd0);
                    if (exp_aw.size() != 0) chk_eq("awaddr", 32'(awaddr), 32'(exp_aw.pop_front()));
                    chk_eq("awprot", 32'(awprot), 32'd0);
                end
                if (wvalid && wready) begin
                    chk(exp_w.size() != 0, "w_extra", wdata, 32'd0);
                    if (exp_w.size() != 0) chk_eq("wdata", wdata, exp_w.pop_front());
                    chk_eq("wstrb", 32'(wstrb), 32'hF);
                end
                if (arvalid && arready) begin
                    chk(exp_ar.size() != 0, "ar_extra", 32'(araddr), 32'd0);
                    if (exp_ar.size() != 0) chk_eq("araddr", 32'(araddr), 32'(exp_ar.pop_front()));
                    chk_eq("arprot", 32'(arprot), 32'd0);
                end
                if (rd_valid && rd_ready) begin
                    chk(exp_rd.size() != 0, "rd_extra", rd_data, 32'd0);
                    if (exp_rd.size() != 0) chk_eq("rd_data", rd_data, exp_rd.pop_front());
                    last_rd = cyc;
                end
                if (wr_valid && wr_ready) last_wr = cyc;
                if (bvalid && bready) last_b = cyc;
                if (done) begin
                    chk(exp_done.size() != 0, "done_extra", 32'(done), 32'd0);
                    if (exp_done.size() != 0) begin
                        dn = exp_done.pop_front();
                        chk_eq("err", 32'(err), 32'(dn.err));
                        if (dn.wr) chk_eq("done_after_b", 32'(cyc - last_b), 32'd1);
                        else       chk_eq("done_after_rd", 32'(cyc - last_rd), 32'd1);
                        if (lat3 && dn.wr) chk_eq("wr_latency", 32'(cyc - last_wr), 32'd3);
                    end
                    busy_exp = 0;
                end else if (!done) begin
                    chk_eq("err_idle", 32'(err), 32'd0);
                end
                if (cmd_valid && cmd_ready) busy_exp = 1;
                pv_aw = awvalid && !awready; p_awa = awaddr;
                pv_w  = wvalid && !wready;   p_wd  = wdata;
                pv_ar = arvalid && !arready; p_ara = araddr;
                pv_rd = rd_valid && !rd_ready; p_rdd = rd_data;
            end
        end
    end

    // Reference model: addresses step by 4 modulo the address space, errors are OR-ed over the run.
    task automatic plan(input bit wr, input logic [AW-1:0] a, input int len, input int err_pct);
        logic [AW-1:0] base, ad;
        logic [31:0] d;
        bit e, any;
        done_t dn;
        base = a & ~AW'(3);
        any = 0;
        for (int i = 0; i <= len; i++) begin
            ad = base + AW'(4 * i);
            if (err_force.size() != 0) e = err_force.pop_front();
            else e = ($urandom_range(0, 99) < err_pct);
            any |= e;
            if (wr) begin
                if (wdata_src.size() != 0) d = wdata_src.pop_front();
                else d = $urandom;
                wr_feed.push_back(d); exp_aw.push_back(ad); exp_w.push_back(d);
                mmem[ad[AW-1:2]] = d; plan_b.push_back(e);
            end else begin
                exp_ar.push_back(ad); exp_rd.push_back(mmem[ad[AW-1:2]]); plan_r.push_back(e);
            end
        end
        dn.wr = wr; dn.err = any;
        exp_done.push_back(dn);
    endtask

    task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input int len);
        int t;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = LW'(len);
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 200);
        chk_eq("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 0; cmd_addr = AW'($urandom); cmd_len = LW'($urandom);
    endtask

    task automatic run(input bit wr, input logic [AW-1:0] a, input int len, input int err_pct);
        int t;
        plan(wr, a, len, err_pct);
        send_cmd(wr, a, len);
        t = 0;
        while (exp_done.size() != 0 && t < 4000) begin @(negedge clk); t++; end
        chk_eq("run_complete", 32'(exp_done.size()), 32'd0);
        @(negedge clk);
        chk_eq("beats_left", 32'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rd.size()), 32'd0);
        exp_done.delete();
    endtask

    initial begin : stim
        logic [31:0] v;
        int t, bad;
        for (int i = 0; i < 1024; i++) begin v = $urandom; smem[i] = v; mmem[i] = v; end
        for (int i = 0; i < 4; i++) begin smem[i] = 32'(i + 1); mmem[i] = 32'(i + 1); end

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk_eq("rst_valids", {27'd0, awvalid, wvalid, arvalid, rd_valid, done}, 32'd0);
        chk_eq("rst_readies", {28'd0, bready, rready, wr_ready, cmd_ready}, 32'd0);
        chk_eq("rst_status", {30'd0, busy, err}, 32'd0);
        chk_eq("rst_payload", awaddr | araddr | wdata | rd_data, 32'd0);
        #1 rst_n = 1;
        #1 chk_eq("cmd_ready_pre_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk_eq("cmd_ready_post_edge", 32'(cmd_ready), 32'd1);

        // Zero-wait single write, then read it back
        lat3 = 1;
        wdata_src.push_back(32'hDEADBEEF);
        run(1, 12'h010, 0, 0);
        lat3 = 0;
        chk_eq("bram_word4", smem[4], 32'hDEADBEEF);
        run(0, 12'h010, 0, 0);

        // Preloaded read with rd_ready toggling
        rd_mode = 1;
        run(0, 12'h000, 3, 0);
        rd_mode = 0;

        // Write run with skewed AW/W handshakes
        max_dly = 2;
        run(1, 12'h000, 3, 0);
        max_dly = 0;

        // Wrap with an error on the first beat, then a clean run
        err_force.push_back(1); err_force.push_back(0);
        run(0, 12'hFFE, 1, 0);
        run(0, 12'h020, 1, 0);

        // Reset while awvalid is up in a len-7 write
        max_dly = 3;
        plan(1, 12'h100, 7, 0);
        send_cmd(1, 12'h100, 7);
        t = 0;
        while (!awvalid && t < 200) begin @(negedge clk); t++; end
        chk_eq("aw_seen", 32'(awvalid), 32'd1);
        #2 rst_n = 0;
        #1 chk_eq("aw_drop", 32'(awvalid), 32'd0);
        chk_eq("w_drop", 32'(wvalid), 32'd0);
        chk_eq("busy_drop", 32'(busy), 32'd0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_rd.delete(); exp_done.delete();
        wr_feed.delete(); plan_b.delete(); plan_r.delete();
        repeat (2) @(negedge clk);
        // Any prefix of the aborted run may have landed; adopt whatever the BRAM holds.
        for (int i = 0; i < 8; i++) mmem[(12'h100 >> 2) + i] = smem[(12'h100 >> 2) + i];
        #1 rst_n = 1;
        run(1, 12'h100, 0, 0);
        run(0, 12'h100, 7, 0);

        // Randomised runs
        for (int k = 0; k < 40; k++) begin
            max_dly = int'($urandom_range(0, 3));
            wr_gap  = int'($urandom_range(0, 2));
            rd_mode = int'($urandom_range(0, 2));
            v = $urandom;
            if (k % 8 == 0) v[11:4] = 8'hFF;
            run(1'($urandom_range(0, 1)), v[AW-1:0], int'($urandom_range(0, 6)), 25);
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) if (smem[i] !== mmem[i]) bad++;
        chk_eq("mem_image", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #900us;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks", n_pass, n_chk);
        $fatal(1);
    end
endmodule
